// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction array: one synchronous write port and one
// synchronous read port with registered read data.
module imem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory with program-load port and a one-cycle
// valid/ready fetch pipeline with flush and fault reporting.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          req_valid,
    input  logic [31:0]   req_pc,
    output logic          req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_pc,
    output logic [1:0]    rsp_fault,
    input  logic          flush,
    output logic [31:0]   fetch_cnt,
    output logic [AW:0]   load_cnt
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_rsp_valid;
    logic          r_rsp_ok;
    fault_e        r_rsp_fault;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_fetch_cnt;
    logic [AW:0]   r_load_cnt;

    logic          w_misalign;
    logic          w_oor;
    fault_e        w_fault;
    logic          w_accept;
    logic          w_rsp_hold;
    logic          w_we;
    logic          w_re;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_rdata;

    assign w_misalign = |req_pc[1:0];
    assign w_oor      = {2'b00, req_pc[31:2]} >= 32'(DEPTH);
    assign w_fault    = w_misalign ? FAULT_MISALIGN :
                        w_oor      ? FAULT_RANGE    : FAULT_OK;
    assign w_raddr    = req_pc[AW+1:2];

    assign req_ready  = (r_state == RUN) && !load_en && !flush &&
                        (!r_rsp_valid || rsp_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_rsp_hold = r_rsp_valid && !rsp_ready && !flush;

    // Only in-range aligned fetches touch the array; faults answer NOP.
    assign w_re = w_accept && (w_fault == FAULT_OK);
    assign w_we = (r_state == LOAD) && load_we &&
                  ({1'b0, load_addr} < DEPTH_CNT);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (load_en && !w_rsp_hold) w_state_nxt = LOAD;
            LOAD:    if (!load_en) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rsp_fault <= FAULT_OK;
            r_rsp_pc    <= '0;
            r_fetch_cnt <= '0;
            r_load_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_rsp_valid <= 1'b0;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept) begin
                r_rsp_pc    <= req_pc;
                r_rsp_fault <= w_fault;
                r_rsp_ok    <= (w_fault == FAULT_OK);
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_state == RUN && w_state_nxt == LOAD) begin
                r_load_cnt <= '0;
            end else if (w_we && r_load_cnt != DEPTH_CNT) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_instr = r_rsp_ok ? w_rdata : NOP_WORD;
    assign rsp_pc    = r_rsp_pc;
    assign rsp_fault = r_rsp_fault;
    assign fetch_cnt = r_fetch_cnt;
    assign load_cnt  = r_load_cnt;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: directed sequences, a vector
// table for fault rules and a randomized run against a reference model.
module tb_imem_ctrl;

    localparam int          DEPTH = 12;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          req_valid;
    logic [31:0]   req_pc;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [31:0]   rsp_pc;
    logic [1:0]    rsp_fault;
    logic          flush;
    logic [31:0]   fetch_cnt;
    logic [AW:0]   load_cnt;

    imem_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .fetch_cnt (fetch_cnt),
        .load_cnt  (load_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: behaviour described at transaction level.
    logic        m_loading;
    logic        m_rv;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [1:0]  m_fault;
    logic [31:0] m_fetch;
    int          m_lcnt;
    logic [31:0] m_mem [DEPTH];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;

    logic [31:0] prog [4];
    vec_t        vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fault_of(input logic [31:0] pc);
        if (pc[1:0] != 2'b00) return 2'b01;
        if (int'(pc >> 2) >= DEPTH || pc[31]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_ready();
        return !m_loading && !load_en && !flush && (!m_rv || rsp_ready);
    endfunction

    task automatic model_step();
        logic acc;
        logic hold;
        logic [1:0] f;
        if (!rst_n) begin
            m_loading = 1'b0;
            m_rv      = 1'b0;
            m_instr   = NOP;
            m_pc      = 32'd0;
            m_fault   = 2'b00;
            m_fetch   = 32'd0;
            m_lcnt    = 0;
            return;
        end
        acc  = req_valid && m_ready();
        hold = m_rv && !rsp_ready && !flush;
        if (!m_loading) begin
            if (load_en && !hold) begin
                m_loading = 1'b1;
                m_lcnt    = 0;
            end
        end else begin
            if (load_we && int'(load_addr) < DEPTH) begin
                m_mem[load_addr] = load_data;
                if (m_lcnt < DEPTH) m_lcnt++;
            end
            if (!load_en) m_loading = 1'b0;
        end
        if (acc) begin
            f       = fault_of(req_pc);
            m_fault = f;
            m_pc    = req_pc;
            m_instr = (f == 2'b00) ? m_mem[req_pc[31:2]] : NOP;
            m_fetch = m_fetch + 32'd1;
        end
        if (flush) m_rv = 1'b0;
        else if (acc) m_rv = 1'b1;
        else if (rsp_ready) m_rv = 1'b0;
    endtask

    task automatic tick();
        #1;
        chk("req_ready", 32'(req_ready), 32'(m_ready()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            chk("rsp_instr", rsp_instr, m_instr);
            chk("rsp_pc", rsp_pc, m_pc);
            chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
        end
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("load_cnt", 32'(load_cnt), 32'(m_lcnt));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        int r;
        prog[0] = 32'h2010000F;
        prog[1] = 32'h20110014;
        prog[2] = 32'h20120024;
        prog[3] = 32'h02329820;
        vecs[0] = '{32'd0,  32'h2010000F, 2'b00};
        vecs[1] = '{32'd4,  32'h20110014, 2'b00};
        vecs[2] = '{32'd8,  32'h20120024, 2'b00};
        vecs[3] = '{32'd12, 32'h02329820, 2'b00};
        vecs[4] = '{32'h6,  NOP,          2'b01};
        vecs[5] = '{32'd48, NOP,          2'b10};
        vecs[6] = '{32'd50, NOP,          2'b01};
        vecs[7] = '{32'd44, 32'hA000_000B, 2'b00};

        rst_n = 1'b0; load_en = 1'b0; load_we = 1'b0;
        load_addr = '0; load_data = '0; req_valid = 1'b0;
        req_pc = '0; rsp_ready = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        model_step();
        chk("reset rsp_instr", rsp_instr, NOP);
        chk("reset rsp_pc", rsp_pc, 32'd0);
        chk("reset rsp_fault", 32'(rsp_fault), 32'd0);
        tick();
        rst_n = 1'b1;

        // Fill whole array; repeated writes must saturate load_cnt.
        load_en = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_we   = 1'b1;
            load_addr = AW'(i % DEPTH);
            load_data = 32'hA000_0000 + 32'(i % DEPTH);
            tick();
        end
        chk("load_cnt saturate", 32'(load_cnt), DEPTH);
        load_we = 1'b0; load_en = 1'b0;
        tick();

        // Program session, with one ignored out-of-range write.
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            load_we = 1'b1; load_addr = AW'(i); load_data = prog[i];
            tick();
        end
        load_addr = AW'(DEPTH); load_data = 32'hFFFF_FFFF;
        tick();
        load_we = 1'b0; load_en = 1'b0;
        tick();
        chk("load_cnt program", 32'(load_cnt), 32'd4);

        // Back-to-back fetch with one-cycle latency.
        saved = m_fetch;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_pc = 32'(4 * k);
            tick();
            chk($sformatf("b2b instr %0d", k), rsp_instr, prog[k]);
        end
        req_valid = 1'b0;
        tick();
        chk("b2b fetch_cnt", fetch_cnt, saved + 32'd4);

        for (int i = 0; i < 8; i++) begin
            fetch1(vecs[i].pc);
            chk($sformatf("vec%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d instr", i), rsp_instr, vecs[i].instr);
            chk($sformatf("vec%0d fault", i), 32'(rsp_fault),
                32'(vecs[i].fault));
            tick();
        end

        // Back-pressure: 3 stalled cycles, then release.
        saved = m_fetch;
        fetch1(32'd8);
        req_valid = 1'b1; req_pc = 32'd12; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall req_ready", 32'(req_ready), 32'd0);
            chk("stall instr", rsp_instr, prog[2]);
            chk("stall pc", rsp_pc, 32'd8);
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("release instr", rsp_instr, prog[3]);
        chk("release pc", rsp_pc, 32'd12);
        tick();
        chk("stall fetch_cnt", fetch_cnt, saved + 32'd2);

        // Flush beats both rsp_ready and acceptance.
        fetch1(32'd4);
        saved = m_fetch;
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'd0; rsp_ready = 1'b0;
        tick();
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        chk("flush rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush fetch_cnt", fetch_cnt, saved);
        tick();

        // Load request while stalled must wait for the consumer.
        fetch1(32'd0);
        rsp_ready = 1'b0; load_en = 1'b1;
        load_we = 1'b1; load_addr = AW'(7); load_data = 32'h1111_1111;
        tick();
        tick();
        chk("stalled load_cnt", 32'(load_cnt), 32'd4);
        rsp_ready = 1'b1; load_we = 1'b0;
        tick();
        chk("enter load_cnt", 32'(load_cnt), 32'd0);
        load_we = 1'b1; load_data = 32'h2222_2222;
        tick();
        chk("write load_cnt", 32'(load_cnt), 32'd1);
        load_we = 1'b0; rst_n = 1'b0;
        tick();
        chk("rst load_cnt", 32'(load_cnt), 32'd0);
        chk("rst fetch_cnt", fetch_cnt, 32'd0);
        rst_n = 1'b1; load_en = 1'b0;
        fetch1(32'd28);
        chk("refetch new", rsp_instr, 32'h2222_2222);
        tick();
        fetch1(32'd0);
        chk("refetch kept", rsp_instr, prog[0]);
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 39) == 0) load_en = ~load_en;
            load_we   = $urandom_range(0, 1) == 1;
            load_addr = AW'($urandom_range(0, (1 << AW) - 1));
            load_data = $urandom;
            req_valid = $urandom_range(0, 9) < 7;
            r = $urandom_range(0, 9);
            if (r < 7) req_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) req_pc = ($urandom_range(0, 63) << 2) | 32'd1;
            else if (r == 8) req_pc = 32'($urandom_range(DEPTH, 200)) << 2;
            else req_pc = $urandom;
            rsp_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Parameterised instruction memory for the MIPS core, replacing the hard-coded combinational program ROM. Holds DEPTH 32-bit words in a writable array, loaded through a program-load port, and serves fetches through a valid/ready request/response pipeline with one-cycle latency, back-pressure, flush, and fault reporting. It sits between the PC/fetch stage and the decode stage.

## Interface
- DEPTH, 64: number of 32-bit instruction words; any value ≥ 2, not necessarily a power of two.
- AW, $clog2(DEPTH): width of the word index on the load port.
- NOP_WORD, 32'h0000_0000: value returned on a fault and on reset.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low.
- load_en  in  1  requests program-load mode.
- load_we  in  1  writes one word when the block is in LOAD.
- load_addr  in  AW  word index to write.
- load_data  in  32  word to write.
- req_valid  in  1  fetch request.
- req_pc  in  32  byte address to fetch.
- req_ready  out  1  the block accepts the request this cycle.
- rsp_valid  out  1  a response is held on the output.
- rsp_ready  in  1  the consumer takes the response.
- rsp_instr  out  32  fetched word, or NOP_WORD on a fault.
- rsp_pc  out  32  PC of the request being answered.
- rsp_fault  out  2  fault code: 00 OK, 01 misaligned, 10 out of range.
- flush  in  1  discards the held response and any request this cycle.
- fetch_cnt  out  32  number of accepted fetches; wraps at 2^32.
- load_cnt  out  AW+1  number of words written in the current LOAD session; saturates.

## Operation
- States: RUN and LOAD.
  - RUN → LOAD when load_en=1 and no response is outstanding after this edge (rsp_valid=0, or the response is being consumed or flushed).
  - LOAD → RUN when load_en=0.
  - Entering LOAD clears load_cnt.
- In LOAD:
  - req_ready=0.
  - A write happens when load_we=1 and load_addr < DEPTH; it increments load_cnt.
  - Writes with load_addr ≥ DEPTH are ignored and not counted.
  - In RUN, load_we is ignored.
- Request acceptance:
  - req_ready = (state==RUN) && !load_en && !flush && (!rsp_valid || rsp_ready).
  - A request is accepted when req_valid && req_ready; fetch_cnt increments by 1.
- Address and fault rules:
  - Word index = req_pc[31:2].
  - If req_pc[1:0]≠0, fault = 01.
  - Otherwise, if the word index ≥ DEPTH, fault = 10.
  - If both conditions hold, misaligned (01) wins.
  - Any fault returns rsp_instr = NOP_WORD.
- Response hold: while rsp_valid=1 and rsp_ready=0, rsp_instr, rsp_pc and rsp_fault stay stable.
- Flush:
  - rsp_valid is 0 after the edge on which flush=1.
  - A simultaneous request is not accepted.
  - flush has priority over rsp_ready and over acceptance.
- Read and write never collide, because reads are blocked in LOAD.
- Array contents survive rst_n; they are not cleared.

## Timing
- Latency: a request accepted at edge N has its response valid after edge N (visible in cycle N+1).
- Throughput: one fetch per cycle while rsp_ready=1.
- Reset (rst_n=0 at an edge) sets:
  - state to RUN;
  - rsp_valid, rsp_fault, fetch_cnt and load_cnt to 0;
  - rsp_instr to NOP_WORD and rsp_pc to 0.
- Reset mid-load drops the load session; words already written stay in the array.
- load_cnt saturates at DEPTH (AW+1 bits) even if the same address is written repeatedly.
- The load write takes effect at the edge; a fetch of that word in a later RUN cycle returns the new value.

## Structure
- imem_pkg holds:
  - the state enum (RUN, LOAD);
  - the fault codes FAULT_OK, FAULT_MISALIGN, FAULT_RANGE;
  - the default NOP_WORD.
- Sub-module imem_ram: a DEPTH×32 array with one synchronous write port and one synchronous read port (registered read data); it maps onto block RAM.
- imem_ctrl contains:
  - the FSM;
  - the handshake logic;
  - the fault registers, aligned with the RAM read stage;
  - the counters.

## Test plan
- Load then fetch: load words 0..3 with 32'h2010000F, 32'h20110014, 32'h20120024, 32'h02329820, then drop load_en. Fetch PCs 0, 4, 8, 12 back-to-back with rsp_ready=1 → the four words return in order, one per cycle, with 1-cycle latency; load_cnt=4 and fetch_cnt=4.
- Back-pressure: hold rsp_ready=0 for 3 cycles with a request pending → rsp_instr and rsp_pc stay stable and req_ready=0; release → the next fetch proceeds, with no loss or duplication.
- Faults: fetch PC 0x6 → fault 01 and NOP; fetch PC 4*DEPTH → fault 10 and NOP; fetch PC 4*DEPTH+2 → fault 01.
- Flush: assert flush together with rsp_valid=1 and req_valid=1 → rsp_valid=0 next cycle, the request is not accepted, and fetch_cnt is unchanged.
- Load-mode entry and reset:
  - Raise load_en while a response is stalled → the block stays in RUN until the response is consumed.
  - A write with load_addr ≥ DEPTH is ignored.
  - rst_n low mid-load → state RUN, counters 0, and array contents preserved on a refetch.
